// File: rtl/lsu_stage.sv
// lsu_stage: RISC-V memory-access stage with a single-outstanding req/ack data port.
// Build macro LSU_MISALIGN_TRAP_EN: trap misaligned accesses instead of forcing alignment.
//
// state | meaning
// IDLE  | accepting ops; non-memory (and trapped) ops write back the next cycle
// REQ   | mem_req held with stable address/enables/data until mem_ack
// RESP  | single writeback beat for the completed memory op
module lsu_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_result,
  input  logic [31:0] in_store_data,
  input  logic [2:0]  in_funct3,
  input  logic        in_is_load,
  input  logic        in_is_store,
  input  logic [4:0]  in_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_exc
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [4:0]  rd_q, rd_d;
  logic        is_load_q, is_load_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic        wb_valid_q, wb_valid_d;
  logic        wb_we_q, wb_we_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        wb_exc_q, wb_exc_d;
  logic        misalign;
`endif

  logic        accept;
  logic        is_mem;
  logic        is_half;
  logic        is_word;
  logic [1:0]  off_eff;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_shift;
  logic [31:0] ld_data;

  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid && in_ready;
  assign is_mem   = in_is_load || in_is_store;
  assign is_half  = (in_funct3[1:0] == 2'b01);
  assign is_word  = in_funct3[1];

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = (is_half && in_result[0]) || (is_word && (in_result[1:0] != 2'b00));
`endif

  // Size-aligned lane offset; only matters when misaligned accesses are not trapped.
  always_comb begin
    off_eff = in_result[1:0];
    if (is_word) begin
      off_eff = 2'b00;
    end else if (is_half) begin
      off_eff[0] = 1'b0;
    end
  end

  always_comb begin
    case (in_funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << off_eff;
        st_wdata = {4{in_store_data[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << off_eff;
        st_wdata = {2{in_store_data[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = in_store_data;
      end
    endcase
  end

  assign ld_shift = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b100:  ld_data = {24'b0, ld_shift[7:0]};
      3'b101:  ld_data = {16'b0, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    off_d       = off_q;
    funct3_d    = funct3_q;
    rd_d        = rd_q;
    is_load_d   = is_load_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    wb_valid_d  = 1'b0;
    wb_we_d     = 1'b0;
    wb_rd_d     = wb_rd_q;
    wb_data_d   = wb_data_q;
`ifdef LSU_MISALIGN_TRAP_EN
    wb_exc_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!is_mem) begin
            wb_valid_d = 1'b1;
            wb_we_d    = 1'b1;
            wb_rd_d    = in_rd;
            wb_data_d  = in_result;
          end
`ifdef LSU_MISALIGN_TRAP_EN
          else if (misalign) begin
            wb_valid_d = 1'b1;
            wb_exc_d   = 1'b1;
            wb_rd_d    = in_rd;
            wb_data_d  = in_result;
          end
`endif
          else begin
            state_d     = REQ;
            off_d       = off_eff;
            funct3_d    = in_funct3;
            rd_d        = in_rd;
            is_load_d   = in_is_load;
            mem_req_d   = 1'b1;
            mem_we_d    = in_is_store;
            mem_addr_d  = {in_result[31:2], 2'b00};
            mem_be_d    = in_is_store ? st_be : 4'b1111;
            mem_wdata_d = in_is_store ? st_wdata : 32'h0;
          end
        end
      end
      REQ: begin
        if (mem_ack) begin
          state_d    = RESP;
          mem_req_d  = 1'b0;
          wb_valid_d = 1'b1;
          wb_we_d    = is_load_q;
          wb_rd_d    = rd_q;
          wb_data_d  = is_load_q ? ld_data : 32'h0;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      off_q       <= 2'b00;
      funct3_q    <= 3'b000;
      rd_q        <= 5'd0;
      is_load_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_be_q    <= 4'h0;
      wb_valid_q  <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_data_q   <= 32'h0;
`ifdef LSU_MISALIGN_TRAP_EN
      wb_exc_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      off_q       <= off_d;
      funct3_q    <= funct3_d;
      rd_q        <= rd_d;
      is_load_q   <= is_load_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      wb_valid_q  <= wb_valid_d;
      wb_we_q     <= wb_we_d;
      wb_rd_q     <= wb_rd_d;
      wb_data_q   <= wb_data_d;
`ifdef LSU_MISALIGN_TRAP_EN
      wb_exc_q    <= wb_exc_d;
`endif
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign wb_valid  = wb_valid_q;
  assign wb_we     = wb_we_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
`ifdef LSU_MISALIGN_TRAP_EN
  assign wb_exc    = wb_exc_q;
`else
  assign wb_exc    = 1'b0;
`endif

endmodule
